// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
//   state_t : FSM encoding of the command master
//   OKAY/EXOKAY/SLVERR/DECERR : AXI response codes
//   cmd_t   : one register command {write, address, data, strobe}
package axi4_lite_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StWrAddrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StRespond
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef struct packed {
        logic                write;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strobe;
    } cmd_t;

endpackage

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master. Turns one register read/write command
// into a complete AXI4-Lite transaction and returns the result.
//   clk_i, rst_clk_i          : clock, asynchronous active-high reset
//   cmd_*                     : command port (valid/ready), latched in idle
//   rsp_*                     : response port (valid/ready), held until taken
//   m_axi_*                   : AXI4-Lite master channels AW, W, B, AR, R
// All outputs come from registers or are decoded from the state register.
module axi4_lite_cmd_master
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned DATA_SIZE    = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_clk_i,

    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [ADDRESS_SIZE-1:0]   cmd_address_i,
    input  logic [DATA_SIZE-1:0]      cmd_data_i,
    input  logic [DATA_SIZE/8-1:0]    cmd_strobe_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic                      rsp_write_o,
    output logic [DATA_SIZE-1:0]      rsp_data_o,
    output logic [1:0]                rsp_resp_o,

    output logic [ADDRESS_SIZE-1:0]   m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_SIZE-1:0]      m_axi_wdata,
    output logic [DATA_SIZE/8-1:0]    m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDRESS_SIZE-1:0]   m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_SIZE-1:0]      m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_aw_done;
    logic                      r_w_done;
    logic [ADDRESS_SIZE-1:0]   r_addr;
    logic [DATA_SIZE-1:0]      r_data;
    logic [DATA_SIZE/8-1:0]    r_strb;
    logic                      r_write;
    logic [DATA_SIZE-1:0]      r_rsp_data;
    logic [1:0]                r_rsp_resp;

    logic                      w_accept;
    logic                      w_aw_hs;
    logic                      w_w_hs;

    assign w_accept = (r_state == StIdle) & cmd_valid_i;
    assign w_aw_hs  = (r_state == StWrAddrData) & ~r_aw_done & m_axi_awready;
    assign w_w_hs   = (r_state == StWrAddrData) & ~r_w_done & m_axi_wready;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:       if (cmd_valid_i) w_state_next = cmd_write_i ? StWrAddrData : StRdAddr;
            // Leave as soon as both channels are done, counting same-cycle handshakes.
            StWrAddrData: if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_state_next = StWrResp;
            StWrResp:     if (m_axi_bvalid)  w_state_next = StRespond;
            StRdAddr:     if (m_axi_arready) w_state_next = StRdData;
            StRdData:     if (m_axi_rvalid)  w_state_next = StRespond;
            StRespond:    if (rsp_ready_i)   w_state_next = StIdle;
            default:      w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_clk_i) begin
        if (rst_clk_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_clk_i) begin
        if (rst_clk_i) begin
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_strb     <= '0;
            r_write    <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_resp <= OKAY;
        end else begin
            if (w_accept) begin
                r_addr    <= cmd_address_i;
                r_data    <= cmd_data_i;
                r_strb    <= cmd_strobe_i;
                r_write   <= cmd_write_i;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if ((r_state == StWrResp) && m_axi_bvalid) begin
                r_rsp_data <= '0;
                r_rsp_resp <= m_axi_bresp;
            end
            if ((r_state == StRdData) && m_axi_rvalid) begin
                r_rsp_data <= m_axi_rdata;
                r_rsp_resp <= m_axi_rresp;
            end
        end
    end

    assign cmd_ready_o   = (r_state == StIdle);
    assign m_axi_awvalid = (r_state == StWrAddrData) & ~r_aw_done;
    assign m_axi_wvalid  = (r_state == StWrAddrData) & ~r_w_done;
    assign m_axi_bready  = (r_state == StWrResp);
    assign m_axi_arvalid = (r_state == StRdAddr);
    assign m_axi_rready  = (r_state == StRdData);
    assign rsp_valid_o   = (r_state == StRespond);

    assign m_axi_awaddr  = r_addr;
    assign m_axi_araddr  = r_addr;
    assign m_axi_wdata   = r_data;
    assign m_axi_wstrb   = r_strb;
    assign rsp_write_o   = r_write;
    assign rsp_data_o    = r_rsp_data;
    assign rsp_resp_o    = r_rsp_resp;

endmodule
